// File: rtl/cpu_fetch.sv
// -----------------------------------------------------------------------------
// cpu_fetch
// Instruction fetch unit of the 6502 core. Reads the opcode and its operand
// bytes from synchronous program memory, hands the opcode to CPU_control via
// IR, uses the adr_mode that CPU_control returns to size the instruction, and
// presents the complete instruction to the execute sequencer over a
// valid/ready handshake. Branches and jumps restart fetch with redirect.
//
// Optional feature macro: FETCH_VECTOR_EN
//   defined   : reset reads the reset vector at FFFC/FFFD and starts there.
//   undefined : reset starts fetching directly at RESET_PC.
//
// Ports
//   clk          in   core clock, all logic on the rising edge
//   rst          in   synchronous active-high reset (beats redirect)
//   mem_adr      out  program memory address (0 when no read is issued)
//   mem_rd       out  read strobe, data returns on mem_data next cycle
//   mem_data     in   read data, valid the cycle after mem_rd
//   IR           out  opcode register, wired to CPU_control.IR
//   adr_mode     in   addressing mode decoded by CPU_control from IR
//   op_lo        out  first operand byte (0 if unused)
//   op_hi        out  second operand byte (0 if unused)
//   pc_next      out  address following the held instruction
//   ins_valid    out  instruction held and complete
//   ins_illegal  out  qualifies ins_valid: adr_mode is ADR_INVAL
//   ins_ready    in   execute accepts the held instruction
//   redirect     in   discard current fetch, restart at redirect_pc
//   redirect_pc  in   new PC
// -----------------------------------------------------------------------------
module cpu_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_adr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  IR,
    input  logic [3:0]  adr_mode,
    output logic [7:0]  op_lo,
    output logic [7:0]  op_hi,
    output logic [15:0] pc_next,
    output logic        ins_valid,
    output logic        ins_illegal,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    // Addressing mode encoding shared with CPU_control.
    localparam logic [3:0] ADR_IMPL  = 4'd0;
    localparam logic [3:0] ADR_IMM   = 4'd1;
    localparam logic [3:0] ADR_ZPG   = 4'd2;
    localparam logic [3:0] ADR_ZPG_I = 4'd3;
    localparam logic [3:0] ADR_X_IND = 4'd4;
    localparam logic [3:0] ADR_IND_Y = 4'd5;
    localparam logic [3:0] ADR_REL   = 4'd6;
    localparam logic [3:0] ADR_ABS   = 4'd7;
    localparam logic [3:0] ADR_ABS_I = 4'd8;
    localparam logic [3:0] ADR_IND   = 4'd9;
    localparam logic [3:0] ADR_INVAL = 4'd15;

    typedef enum logic [3:0] {
        S_OPC,
        S_OPW,
        S_DEC,
        S_OP1,
        S_OP2,
        S_HOLD,
        S_VLO,
        S_VHI,
        S_VCAP
    } state_t;

`ifdef FETCH_VECTOR_EN
    localparam state_t RESET_STATE = S_VLO;
`else
    localparam state_t RESET_STATE = S_OPC;
`endif

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [7:0]  ir_n, lo_n, hi_n;
    logic        ill_q, ill_n;
    logic [1:0]  len_q, len_n;
    logic [1:0]  dec_len;
    logic        dec_ill;
    logic        rd;
    logic [15:0] adr;

    // Operand count for the current opcode. Codes CPU_control never produces
    // are treated like ADR_INVAL so they can never be executed silently.
    always_comb begin
        dec_len = 2'd0;
        dec_ill = 1'b0;
        case (adr_mode)
            ADR_IMPL:                        dec_len = 2'd0;
            ADR_IMM, ADR_ZPG, ADR_ZPG_I,
            ADR_X_IND, ADR_IND_Y, ADR_REL:   dec_len = 2'd1;
            ADR_ABS, ADR_ABS_I, ADR_IND:     dec_len = 2'd2;
            ADR_INVAL:                       dec_ill = 1'b1;
            default:                         dec_ill = 1'b1;
        endcase
    end

    // Next-state logic. Every read is issued at PC and post-increments it, so
    // in HOLD the PC already points past the instruction. The HOLD read on
    // ins_ready plays the role of OPC for the next instruction.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = IR;
        lo_n    = op_lo;
        hi_n    = op_hi;
        ill_n   = ill_q;
        len_n   = len_q;
        rd      = 1'b0;
        adr     = 16'h0000;
        case (state)
            S_OPC: begin
                rd      = 1'b1;
                adr     = pc;
                pc_n    = pc + 16'd1;
                state_n = S_OPW;
            end
            S_OPW: begin
                ir_n    = mem_data;
                lo_n    = 8'h00;
                hi_n    = 8'h00;
                state_n = S_DEC;
            end
            S_DEC: begin
                len_n = dec_len;
                ill_n = dec_ill;
                if (dec_len != 2'd0) begin
                    rd      = 1'b1;
                    adr     = pc;
                    pc_n    = pc + 16'd1;
                    state_n = S_OP1;
                end else begin
                    state_n = S_HOLD;
                end
            end
            S_OP1: begin
                lo_n = mem_data;
                if (len_q == 2'd2) begin
                    rd      = 1'b1;
                    adr     = pc;
                    pc_n    = pc + 16'd1;
                    state_n = S_OP2;
                end else begin
                    state_n = S_HOLD;
                end
            end
            S_OP2: begin
                hi_n    = mem_data;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (ins_ready) begin
                    rd      = 1'b1;
                    adr     = pc;
                    pc_n    = pc + 16'd1;
                    state_n = S_OPW;
                end
            end
`ifdef FETCH_VECTOR_EN
            S_VLO: begin
                rd      = 1'b1;
                adr     = 16'hFFFC;
                state_n = S_VHI;
            end
            S_VHI: begin
                pc_n[7:0] = mem_data;
                rd        = 1'b1;
                adr       = 16'hFFFD;
                state_n   = S_VCAP;
            end
            S_VCAP: begin
                pc_n[15:8] = mem_data;
                state_n    = S_OPC;
            end
`endif
            default: state_n = S_OPC;
        endcase

        // Redirect overrides everything: no read is issued, in-flight data is
        // dropped and the held instruction registers are left untouched.
        if (redirect) begin
            state_n = S_OPC;
            pc_n    = redirect_pc;
            ir_n    = IR;
            lo_n    = op_lo;
            hi_n    = op_hi;
            ill_n   = ill_q;
            len_n   = len_q;
            rd      = 1'b0;
            adr     = 16'h0000;
        end
    end

    // State and instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_STATE;
            pc    <= RESET_PC;
            IR    <= 8'h00;
            op_lo <= 8'h00;
            op_hi <= 8'h00;
            ill_q <= 1'b0;
            len_q <= 2'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            IR    <= ir_n;
            op_lo <= lo_n;
            op_hi <= hi_n;
            ill_q <= ill_n;
            len_q <= len_n;
        end
    end

    // The entry state issues a read combinationally, so the memory port is
    // masked while reset is held to keep it idle until reset is released.
    assign mem_rd      = rd & ~rst;
    assign mem_adr     = rst ? 16'h0000 : adr;
    assign ins_valid   = (state == S_HOLD);
    assign ins_illegal = (state == S_HOLD) & ill_q;
    assign pc_next     = pc;

endmodule
